// File: rtl/noise_rd_pkg.sv
// Shared types and widths for the noise-acquisition RAM reader.
package noise_rd_pkg;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned OUT_W    = 16;
  localparam int unsigned CNT_W    = 12;

  typedef enum logic [2:0] {
    IDLE,
    ARST,
    STROBE,
    WAIT,
    PRESENT,
    CKSUM,
    DONE
  } state_t;

endpackage

// File: rtl/noise_rd_cksum.sv
// Modulo-2^16 running sum of streamed words; used only when NOISE_RD_CHECKSUM_EN is defined.
module noise_rd_cksum
  import noise_rd_pkg::*;
(
  input  logic             clk_sys,
  input  logic             n_reset,
  input  logic             clr,
  input  logic             add_en,
  input  logic [OUT_W-1:0] add_val,
  output logic [OUT_W-1:0] sum
);

  always_ff @(posedge clk_sys or negedge n_reset) begin
    if (!n_reset) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + add_val;
    end
  end

endmodule

// File: rtl/noise_rd_ctrl.sv
// Drains the noise-acquisition RAM and streams samples on a valid/ready port.
// Optional trailing checksum word: define NOISE_RD_CHECKSUM_EN.
module noise_rd_ctrl
  import noise_rd_pkg::*;
#(
  parameter int unsigned RAM_LAT = 1
)
(
  input  logic                clk_sys,
  input  logic                n_reset,
  input  logic                rd_start,
  input  logic                rd_abort,
  input  logic [CNT_W-1:0]    rd_num,
  input  logic [SAMPLE_W-1:0] RAM_data,
  output logic                RAM_RDaddr_rst,
  output logic                RAM_RD_EN,
  output logic                XRD,
  output logic [OUT_W-1:0]    dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                busy,
  output logic                done
);

  state_t state, state_nx;

  logic [CNT_W-1:0]    num_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          wcnt_q;
  logic [SAMPLE_W-1:0] cap_q;
  logic [OUT_W-1:0]    sample_ext;
  logic                hs;
  logic                last;
  logic                wait_end;
  logic                accept;

  assign accept     = (state == IDLE) && rd_start && !rd_abort;
  assign hs         = dout_valid && dout_ready;
  assign last       = (cnt_q == (num_q - CNT_W'(1)));
  assign wait_end   = (wcnt_q == 3'(RAM_LAT - 1));
  assign sample_ext = OUT_W'(cap_q);

`ifdef NOISE_RD_CHECKSUM_EN
  logic [OUT_W-1:0] sum;

  noise_rd_cksum u_cksum (
    .clk_sys (clk_sys),
    .n_reset (n_reset),
    .clr     (state == ARST),
    .add_en  ((state == PRESENT) && hs),
    .add_val (sample_ext),
    .sum     (sum)
  );
`endif

  always_ff @(posedge clk_sys or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ARST;
`ifdef NOISE_RD_CHECKSUM_EN
      ARST:    state_nx = (num_q != '0) ? STROBE : CKSUM;
`else
      ARST:    state_nx = (num_q != '0) ? STROBE : DONE;
`endif
      STROBE:  state_nx = WAIT;
      WAIT:    if (wait_end) state_nx = PRESENT;
`ifdef NOISE_RD_CHECKSUM_EN
      PRESENT: if (hs) state_nx = last ? CKSUM : STROBE;
      CKSUM:   if (hs) state_nx = DONE;
`else
      PRESENT: if (hs) state_nx = last ? DONE : STROBE;
`endif
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Abort overrides every transition, including a start seen in the same IDLE cycle.
    if (rd_abort) state_nx = IDLE;
  end

  always_ff @(posedge clk_sys or negedge n_reset) begin
    if (!n_reset) begin
      num_q  <= '0;
      cnt_q  <= '0;
      wcnt_q <= '0;
      cap_q  <= '0;
    end else begin
      if (accept) num_q <= rd_num;

      if (state == ARST) begin
        cnt_q <= '0;
      end else if ((state == PRESENT) && hs) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (state == STROBE) begin
        wcnt_q <= '0;
      end else if (state == WAIT) begin
        wcnt_q <= wcnt_q + 3'd1;
      end

      // Clearing on IDLE entry drops any pending word on abort and parks dout at zero.
      if (state_nx == IDLE) begin
        cap_q <= '0;
      end else if ((state == WAIT) && wait_end) begin
        cap_q <= RAM_data;
      end
    end
  end

  always_comb begin
    RAM_RDaddr_rst = (state != ARST);
    XRD            = (state != STROBE);
    RAM_RD_EN      = (state != IDLE);
    busy           = (state != IDLE);
    done           = (state == DONE);
    dout_valid     = (state == PRESENT);
    dout           = sample_ext;
`ifdef NOISE_RD_CHECKSUM_EN
    if (state == CKSUM) begin
      dout_valid = 1'b1;
      dout       = sum;
    end
`endif
  end

endmodule

// File: tb/tb_noise_rd_ctrl.sv
// Directed scoreboard bench for noise_rd_ctrl; follows NOISE_RD_CHECKSUM_EN if defined.
`timescale 1ns/1ps
module tb_noise_rd_ctrl;

  logic        clk_sys = 1'b0;
  logic        n_reset = 1'b0;
  logic        rd_start = 1'b0;
  logic        rd_abort = 1'b0;
  logic        dout_ready = 1'b1;
  logic [11:0] rd_num = '0;
  logic [11:0] RAM_data;
  logic        RAM_RDaddr_rst, RAM_RD_EN, XRD, dout_valid, busy, done;
  logic [15:0] dout;

  logic [11:0] mem [4096];
  logic [11:0] raddr;
  logic [11:0] ram_q;
  logic [15:0] exp_q [$];
  int          hs_cyc [$];

  int checks = 0, errors = 0, cyc = 0;
  int hs_cnt = 0, xrd_cnt = 0, arst_cnt = 0, done_cnt = 0, done_cyc = 0, c0 = 0;

  localparam logic [21:0] RESET_VEC = {1'b1, 1'b1, 4'b0000, 16'h0000};

  noise_rd_ctrl #(.RAM_LAT(1)) dut (
    .clk_sys        (clk_sys),
    .n_reset        (n_reset),
    .rd_start       (rd_start),
    .rd_abort       (rd_abort),
    .rd_num         (rd_num),
    .RAM_data       (RAM_data),
    .RAM_RDaddr_rst (RAM_RDaddr_rst),
    .RAM_RD_EN      (RAM_RD_EN),
    .XRD            (XRD),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .dout_ready     (dout_ready),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // RAM read port: address reset, one word per XRD low cycle, one-cycle latency.
  always @(posedge clk_sys or negedge n_reset) begin
    if (!n_reset) begin
      raddr <= '0;
      ram_q <= '0;
    end else if (!RAM_RDaddr_rst) begin
      raddr <= '0;
    end else if (!XRD) begin
      ram_q <= mem[raddr];
      raddr <= raddr + 12'd1;
    end
  end
  assign RAM_data = ram_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] out_vec();
    return {RAM_RDaddr_rst, XRD, RAM_RD_EN, dout_valid, busy, done, dout};
  endfunction

  // Monitor: inputs settle at the falling edge, so this sees what the next rising edge will see.
  always begin
    @(negedge clk_sys);
    #2;
    if (n_reset) begin
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) chk("scoreboard_underflow", 32'(exp_q.size()), 1);
        else chk("dout", 32'(dout), 32'(exp_q.pop_front()));
        hs_cnt++;
        hs_cyc.push_back(cyc);
      end
      if (!XRD) xrd_cnt++;
      if (!RAM_RDaddr_rst) arst_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_stats();
    hs_cnt = 0; xrd_cnt = 0; arst_cnt = 0; done_cnt = 0; done_cyc = 0;
    hs_cyc.delete();
  endtask

  task automatic start(input logic [11:0] n);
    logic [15:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < 32'(n); i++) begin
      exp_q.push_back({4'b0000, mem[i]});
      sum = sum + {4'b0000, mem[i]};
    end
`ifdef NOISE_RD_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
    @(negedge clk_sys);
    rd_num = n;
    rd_start = 1'b1;
    c0 = cyc;
    @(negedge clk_sys);
    rd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk_sys);
    chk({tag, "_timeout"}, 32'(done_cnt != 0), 1);
    repeat (4) @(negedge clk_sys);
  endtask

  int n_words;
  int n;
  logic [15:0] held;
  int x0;

  initial begin
`ifdef NOISE_RD_CHECKSUM_EN
    n_words = 1;
`else
    n_words = 0;
`endif
    for (int unsigned i = 0; i < 4096; i++) mem[i] = 12'(i * 37 + 5);
    mem[0] = 12'h001; mem[1] = 12'h002; mem[2] = 12'hFFF; mem[3] = 12'h800;

    // Reset and idle
    repeat (3) @(negedge clk_sys);
    chk("in_reset", 32'(out_vec()), 32'(RESET_VEC));
    n_reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      chk("idle", 32'(out_vec()), 32'(RESET_VEC));
    end

    // Basic read of four samples
    clear_stats();
    start(12'd4);
    wait_done("basic", 100);
    chk("basic_arst", 32'(arst_cnt), 1);
    chk("basic_xrd", 32'(xrd_cnt), 4);
    chk("basic_done", 32'(done_cnt), 1);
    chk("basic_words", 32'(hs_cnt), 32'(4 + n_words));
    if (hs_cyc.size() >= 4) begin
      chk("basic_first_latency", 32'(hs_cyc[0] - c0), 4);
      for (int i = 1; i < 4; i++) chk("basic_period", 32'(hs_cyc[i] - hs_cyc[i-1]), 3);
      chk("basic_done_cycle", 32'(done_cyc), 32'(hs_cyc[hs_cyc.size()-1] + 1));
    end
    chk("basic_sb_empty", 32'(exp_q.size()), 0);
    chk("basic_idle_after", 32'(out_vec()), 32'(RESET_VEC));

    // Backpressure on the second word
    clear_stats();
    start(12'd4);
    for (int i = 0; i < 50 && !(dout_valid && hs_cnt == 1); i++) @(negedge clk_sys);
    chk("bp_reach_word2", 32'(dout_valid && hs_cnt == 1), 1);
    dout_ready = 1'b0;
    held = dout;
    x0 = xrd_cnt;
    chk("bp_word2_value", 32'(held), 32'h0002);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      chk("bp_valid_held", 32'(dout_valid), 1);
      chk("bp_dout_held", 32'(dout), 32'(held));
    end
    chk("bp_no_xrd", 32'(xrd_cnt), 32'(x0));
    dout_ready = 1'b1;
    wait_done("bp", 100);
    chk("bp_xrd", 32'(xrd_cnt), 4);
    chk("bp_words", 32'(hs_cnt), 32'(4 + n_words));
    chk("bp_done", 32'(done_cnt), 1);
    chk("bp_sb_empty", 32'(exp_q.size()), 0);

    // Zero-length transfer
    clear_stats();
    start(12'd0);
    wait_done("zero", 50);
    chk("zero_xrd", 32'(xrd_cnt), 0);
    chk("zero_words", 32'(hs_cnt), 32'(n_words));
    chk("zero_done_cycle", 32'(done_cyc - c0), 32'(2 + n_words));
    chk("zero_sb_empty", 32'(exp_q.size()), 0);

    // Start and abort together in IDLE: abort wins
    clear_stats();
    @(negedge clk_sys);
    rd_num = 12'd5; rd_start = 1'b1; rd_abort = 1'b1;
    @(negedge clk_sys);
    rd_start = 1'b0; rd_abort = 1'b0;
    chk("startabort_busy", 32'(busy), 0);
    @(negedge clk_sys);
    chk("startabort_arst", 32'(arst_cnt), 0);

    // Abort in the WAIT of sample 2 of 10, with an ignored start while busy
    clear_stats();
    start(12'd10);
    n = 0;
    for (int i = 0; i < 50 && n < 1; i++) begin
      @(negedge clk_sys);
      if (!XRD) n++;
    end
    @(negedge clk_sys);
    rd_num = 12'd3; rd_start = 1'b1;
    @(negedge clk_sys);
    rd_start = 1'b0;
    for (int i = 0; i < 50 && n < 2; i++) begin
      @(negedge clk_sys);
      if (!XRD) n++;
    end
    chk("abort_reach_xrd2", 32'(n), 2);
    @(negedge clk_sys);
    rd_abort = 1'b1;
    @(negedge clk_sys);
    rd_abort = 1'b0;
    chk("abort_outputs", 32'(out_vec()), 32'(RESET_VEC));
    chk("abort_words", 32'(hs_cnt), 1);
    chk("abort_busy_start_ignored", 32'(arst_cnt), 1);
    exp_q.delete();
    repeat (5) @(negedge clk_sys);
    chk("abort_no_done", 32'(done_cnt), 0);

    // Restart after abort: full ten-sample transfer
    clear_stats();
    start(12'd10);
    wait_done("restart", 200);
    chk("restart_arst", 32'(arst_cnt), 1);
    chk("restart_xrd", 32'(xrd_cnt), 10);
    chk("restart_words", 32'(hs_cnt), 32'(10 + n_words));
    chk("restart_done", 32'(done_cnt), 1);
    if (hs_cyc.size() >= 1) chk("restart_first_latency", 32'(hs_cyc[0] - c0), 4);
    chk("restart_sb_empty", 32'(exp_q.size()), 0);

    // Async reset mid-transfer
    clear_stats();
    start(12'd6);
    repeat (5) @(negedge clk_sys);
    #1 n_reset = 1'b0;
    #1 chk("areset_outputs", 32'(out_vec()), 32'(RESET_VEC));
    exp_q.delete();
    @(negedge clk_sys);
    n_reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("areset_no_done", 32'(done_cnt), 0);
    chk("areset_idle", 32'(out_vec()), 32'(RESET_VEC));

    // Maximum length: 4095 samples, no counter wrap
    clear_stats();
    start(12'd4095);
    wait_done("max", 15000);
    chk("max_xrd", 32'(xrd_cnt), 4095);
    chk("max_words", 32'(hs_cnt), 32'(4095 + n_words));
    chk("max_done", 32'(done_cnt), 1);
    chk("max_sb_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
